// File: rtl/conv_pkg.sv
// Shared helpers for the streaming convolution window generator:
// counter sizing and the window element bit-offset mapping.
package conv_pkg;

   // Bits needed to count 0..n-1, never less than one bit
   function automatic int cnt_bits(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Bit offset of window element (r,c,ch); r=0 is the top row, c=0 the left column
   function automatic int win_offset(input int r, input int c, input int ch,
                                     input int k, input int channels, input int data_bits);
      return ((r * k + c) * channels + ch) * data_bits;
   endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// One frame-row column store: a single address per beat, the old entry is
// read combinationally while the new one is written at the clock edge.
module conv_line_buffer
   import conv_pkg::*;
#(
   parameter int DEPTH  = 28,
   parameter int DATA_W = 8,
   parameter int ADDR_W = cnt_bits(DEPTH)
)(
   input  logic              clk,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem [DEPTH];

   assign rd_data = mem[addr];

   // Replace the column entry after its old value has been consumed by the read port
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[addr] <= wr_data;
      end
   end

endmodule

// File: rtl/conv_window_gen.sv
// Streaming KxK x CHANNELS window generator with configurable stride,
// valid/ready handshakes on both sides and frame position tagging.
module conv_window_gen
   import conv_pkg::*;
#(
   parameter int WIDTH       = 28,
   parameter int HEIGHT      = 28,
   parameter int DATA_BITS   = 8,
   parameter int FILTER_SIZE = 5,
   parameter int CHANNELS    = 1,
   parameter int STRIDE      = 1
)(
   input  logic                                                  clk,
   input  logic                                                  rst,
   input  logic                                                  in_valid,
   output logic                                                  in_ready,
   input  logic [CHANNELS*DATA_BITS-1:0]                         data_in,
   output logic                                                  out_valid,
   input  logic                                                  out_ready,
   output logic [FILTER_SIZE*FILTER_SIZE*CHANNELS*DATA_BITS-1:0] data_out,
   output logic [$clog2(HEIGHT)-1:0]                             out_row,
   output logic [$clog2(WIDTH)-1:0]                              out_col,
   output logic                                                  out_last
);

   localparam int K        = FILTER_SIZE;
   localparam int PIX_BITS = CHANNELS * DATA_BITS;
   localparam int ROW_BITS = $clog2(HEIGHT);
   localparam int COL_BITS = $clog2(WIDTH);
   localparam int PH_BITS  = cnt_bits(STRIDE);
   localparam int LAST_ROW = K - 1 + ((HEIGHT - K) / STRIDE) * STRIDE;
   localparam int LAST_COL = K - 1 + ((WIDTH - K) / STRIDE) * STRIDE;

   logic [COL_BITS-1:0] col_cnt;
   logic [ROW_BITS-1:0] row_cnt;
   logic [PH_BITS-1:0]  col_ph;
   logic [PH_BITS-1:0]  row_ph;
   logic                accept;
   logic                col_at_end;
   logic                row_at_end;
   logic                emit;
   logic                frame_last;

   logic [PIX_BITS-1:0]      lb_rd    [K-1];
   logic [PIX_BITS-1:0]      win      [K][K];
   logic [PIX_BITS-1:0]      next_win [K][K];
   logic [K*K*PIX_BITS-1:0]  next_flat;

   // A new pixel may enter only when the output slot is free or being drained
   assign in_ready   = !rst && (!out_valid || out_ready);
   assign accept     = in_valid && in_ready;
   assign col_at_end = (col_cnt == COL_BITS'(WIDTH - 1));
   assign row_at_end = (row_cnt == ROW_BITS'(HEIGHT - 1));

   // The phase counters sit at zero exactly on stride-aligned rows/columns past the first K-1
   assign emit       = (row_cnt >= ROW_BITS'(K - 1)) && (col_cnt >= COL_BITS'(K - 1)) &&
                       (row_ph == '0) && (col_ph == '0);
   assign frame_last = (row_cnt == ROW_BITS'(LAST_ROW)) && (col_cnt == COL_BITS'(LAST_COL));

   // Raster position of the next pixel plus stride phase, wrapping at row and frame ends
   always_ff @(posedge clk) begin
      if (rst) begin
         col_cnt <= '0;
         row_cnt <= '0;
         col_ph  <= '0;
         row_ph  <= '0;
      end else if (accept) begin
         if (col_at_end) begin
            col_cnt <= '0;
            col_ph  <= '0;
            if (row_at_end) begin
               row_cnt <= '0;
               row_ph  <= '0;
            end else begin
               row_cnt <= row_cnt + 1'b1;
               if (row_cnt >= ROW_BITS'(K - 1)) begin
                  row_ph <= (row_ph == PH_BITS'(STRIDE - 1)) ? '0 : row_ph + 1'b1;
               end
            end
         end else begin
            col_cnt <= col_cnt + 1'b1;
            if (col_cnt >= COL_BITS'(K - 1)) begin
               col_ph <= (col_ph == PH_BITS'(STRIDE - 1)) ? '0 : col_ph + 1'b1;
            end
         end
      end
   end

   // Line buffers: buffer 0 holds the oldest row; each one takes the row below it, the last takes the new pixel
   for (genvar i = 0; i < K - 1; i++) begin : g_lb
      logic [PIX_BITS-1:0] wr_data;
      if (i == K - 2) begin : g_bottom
         assign wr_data = data_in;
      end else begin : g_upper
         assign wr_data = lb_rd[i+1];
      end
      conv_line_buffer #(
         .DEPTH  (WIDTH),
         .DATA_W (PIX_BITS),
         .ADDR_W (COL_BITS)
      ) u_lb (
         .clk     (clk),
         .wr_en   (accept),
         .addr    (col_cnt),
         .wr_data (wr_data),
         .rd_data (lb_rd[i])
      );
   end

   // Window after this beat: shift left one column, new right column is {line buffers, new pixel}
   always_comb begin
      next_flat = '0;
      for (int r = 0; r < K; r++) begin
         for (int c = 0; c < K - 1; c++) begin
            next_win[r][c] = win[r][c+1];
         end
      end
      for (int r = 0; r < K - 1; r++) begin
         next_win[r][K-1] = lb_rd[r];
      end
      next_win[K-1][K-1] = data_in;
      for (int r = 0; r < K; r++) begin
         for (int c = 0; c < K; c++) begin
            next_flat[win_offset(r, c, 0, K, CHANNELS, DATA_BITS) +: PIX_BITS] = next_win[r][c];
         end
      end
   end

   // Window register advances on every accepted pixel; contents before a full window are don't-care
   always_ff @(posedge clk) begin
      if (accept) begin
         win <= next_win;
      end
   end

   // Output slot: load on an emitting pixel, hold while stalled, clear once drained
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         data_out  <= '0;
         out_row   <= '0;
         out_col   <= '0;
         out_last  <= 1'b0;
      end else if (accept) begin
         out_valid <= emit;
         if (emit) begin
            data_out <= next_flat;
            out_row  <= row_cnt - ROW_BITS'(K - 1);
            out_col  <= col_cnt - COL_BITS'(K - 1);
            out_last <= frame_last;
         end
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_conv_window_gen.sv
// Self-checking bench: two 6x6, K=3, 2-channel instances (stride 1 and stride 2)
// checked against a frame-image reference model kept in the bench.
module tb_conv_window_gen;

   localparam int W    = 6;
   localparam int H    = 6;
   localparam int K    = 3;
   localparam int C    = 2;
   localparam int DB   = 8;
   localparam int PIX  = C * DB;
   localparam int OUTW = K * K * PIX;
   localparam int RB   = 3;
   localparam int CB   = 3;
   localparam int LOGN = 256;

   logic clk = 1'b0;
   logic rst;
   logic            in_valid  [2];
   logic            in_ready  [2];
   logic            out_valid [2];
   logic            out_ready [2];
   logic            out_last  [2];
   logic [PIX-1:0]  data_in   [2];
   logic [OUTW-1:0] data_out  [2];
   logic [RB-1:0]   out_row   [2];
   logic [CB-1:0]   out_col   [2];
   logic            rnd_ready [2];

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state, owned by the monitor
   logic            pend      [2];
   logic [OUTW-1:0] exp_data  [2];
   int              exp_row   [2];
   int              exp_col   [2];
   logic            exp_last  [2];
   logic            acc_prev  [2];
   logic            emit_prev [2];
   logic            hold_prev [2];
   logic [OUTW-1:0] held_data [2];
   int              pos_r     [2];
   int              pos_c     [2];
   logic [PIX-1:0]  img       [2][H][W];
   logic [OUTW-1:0] log_data  [2][LOGN];
   int              log_row   [2][LOGN];
   int              log_col   [2][LOGN];
   logic            log_last  [2][LOGN];
   int              log_n     [2] = '{0, 0};
   logic            rst_prev = 1'b0;

   int first_v [9] = '{0, 1, 2, 6, 7, 8, 12, 13, 14};
   int last_v  [9] = '{21, 22, 23, 27, 28, 29, 33, 34, 35};
   int mid_v   [9] = '{7, 8, 9, 13, 14, 15, 19, 20, 21};

   always #5 clk = ~clk;

   conv_window_gen #(
      .WIDTH (W), .HEIGHT (H), .DATA_BITS (DB), .FILTER_SIZE (K), .CHANNELS (C), .STRIDE (1)
   ) dut_s1 (
      .clk (clk), .rst (rst), .in_valid (in_valid[0]), .in_ready (in_ready[0]),
      .data_in (data_in[0]), .out_valid (out_valid[0]), .out_ready (out_ready[0]),
      .data_out (data_out[0]), .out_row (out_row[0]), .out_col (out_col[0]), .out_last (out_last[0])
   );

   conv_window_gen #(
      .WIDTH (W), .HEIGHT (H), .DATA_BITS (DB), .FILTER_SIZE (K), .CHANNELS (C), .STRIDE (2)
   ) dut_s2 (
      .clk (clk), .rst (rst), .in_valid (in_valid[1]), .in_ready (in_ready[1]),
      .data_in (data_in[1]), .out_valid (out_valid[1]), .out_ready (out_ready[1]),
      .data_out (data_out[1]), .out_row (out_row[1]), .out_col (out_col[1]), .out_last (out_last[1])
   );

   task automatic checkOutput(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int strideOf(input int g);
      return (g == 0) ? 1 : 2;
   endfunction

   function automatic logic [PIX-1:0] rampPix(input int r, input int c);
      logic [PIX-1:0] p;
      p[DB-1:0]    = DB'(r * W + c);
      p[PIX-1:DB]  = DB'(r * W + c + 100);
      return p;
   endfunction

   function automatic logic [OUTW-1:0] packList(input int v [9]);
      logic [OUTW-1:0] o;
      o = '0;
      for (int i = 0; i < 9; i++) begin
         o[i*PIX +: DB]      = DB'(v[i]);
         o[i*PIX + DB +: DB] = DB'(v[i] + 100);
      end
      return o;
   endfunction

   function automatic logic [OUTW-1:0] rampWin(input int tr, input int tc);
      int v [9];
      for (int r = 0; r < K; r++)
         for (int c = 0; c < K; c++)
            v[r*K + c] = (tr + r) * W + tc + c;
      return packList(v);
   endfunction

   function automatic logic [OUTW-1:0] modelWin(input int g, input int tr, input int tc);
      logic [OUTW-1:0] o;
      o = '0;
      for (int r = 0; r < K; r++)
         for (int c = 0; c < K; c++)
            for (int ch = 0; ch < C; ch++)
               o[((r*K + c)*C + ch)*DB +: DB] = img[g][tr+r][tc+c][ch*DB +: DB];
      return o;
   endfunction

   // Monitor and scoreboard: sample half a cycle away from the active edge
   always @(negedge clk) begin
      for (int g = 0; g < 2; g++) begin
         if (rst) begin
            checkOutput("rst_in_ready", in_ready[g], 1'b0);
            if (rst_prev) begin
               checkOutput("rst_out_valid", out_valid[g], 1'b0);
               checkOutput("rst_data_out", data_out[g], '0);
               checkOutput("rst_out_row", out_row[g], '0);
               checkOutput("rst_out_col", out_col[g], '0);
               checkOutput("rst_out_last", out_last[g], 1'b0);
            end
            pend[g]      = 1'b0;
            acc_prev[g]  = 1'b0;
            emit_prev[g] = 1'b0;
            hold_prev[g] = 1'b0;
            pos_r[g]     = 0;
            pos_c[g]     = 0;
         end else begin
            int s;
            s = strideOf(g);
            if (acc_prev[g])
               checkOutput("emit_latency", out_valid[g], emit_prev[g]);
            if (hold_prev[g]) begin
               checkOutput("hold_valid", out_valid[g], 1'b1);
               checkOutput("hold_data", data_out[g], held_data[g]);
            end
            checkOutput("in_ready", in_ready[g], !out_valid[g] || out_ready[g]);
            hold_prev[g] = out_valid[g] && !out_ready[g];
            held_data[g] = data_out[g];
            if (out_valid[g] && out_ready[g]) begin
               checkOutput("window_expected", pend[g], 1'b1);
               if (pend[g]) begin
                  checkOutput("win_data", data_out[g], exp_data[g]);
                  checkOutput("win_row", out_row[g], exp_row[g]);
                  checkOutput("win_col", out_col[g], exp_col[g]);
                  checkOutput("win_last", out_last[g], exp_last[g]);
               end
               if (log_n[g] < LOGN) begin
                  log_data[g][log_n[g]] = data_out[g];
                  log_row[g][log_n[g]]  = int'(out_row[g]);
                  log_col[g][log_n[g]]  = int'(out_col[g]);
                  log_last[g][log_n[g]] = out_last[g];
                  log_n[g]++;
               end
               pend[g] = 1'b0;
            end
            acc_prev[g]  = in_valid[g] && in_ready[g];
            emit_prev[g] = 1'b0;
            if (acc_prev[g]) begin
               img[g][pos_r[g]][pos_c[g]] = data_in[g];
               if (pos_r[g] >= K-1 && pos_c[g] >= K-1 &&
                   (pos_r[g]-K+1) % s == 0 && (pos_c[g]-K+1) % s == 0) begin
                  emit_prev[g] = 1'b1;
                  checkOutput("window_overrun", pend[g], 1'b0);
                  pend[g]     = 1'b1;
                  exp_row[g]  = pos_r[g] - K + 1;
                  exp_col[g]  = pos_c[g] - K + 1;
                  exp_data[g] = modelWin(g, exp_row[g], exp_col[g]);
                  exp_last[g] = (exp_row[g] == ((H-K)/s)*s) && (exp_col[g] == ((W-K)/s)*s);
               end
               if (pos_c[g] == W-1) begin
                  pos_c[g] = 0;
                  pos_r[g] = (pos_r[g] == H-1) ? 0 : pos_r[g] + 1;
               end else begin
                  pos_c[g]++;
               end
            end
         end
      end
      rst_prev = rst;
   end

   task automatic tick(input int g);
      @(posedge clk);
      #1;
      if (rnd_ready[g]) out_ready[g] = ($urandom_range(0, 3) != 0);
   endtask

   task automatic sendPixel(input int g, input logic [PIX-1:0] pix, input int gap_max);
      int   waited;
      logic acc;
      waited = 0;
      acc    = 1'b0;
      in_valid[g] = 1'b1;
      data_in[g]  = pix;
      while (!acc && waited < 200) begin
         @(negedge clk);
         acc = in_ready[g];
         tick(g);
         waited++;
      end
      if (!acc) checkOutput("accept_timeout", 1'b1, 1'b0);
      repeat ($urandom_range(0, gap_max)) begin
         in_valid[g] = 1'b0;
         tick(g);
      end
   endtask

   task automatic applyStimulus(input int g, input int mode, input int frames, input int gap_max);
      for (int f = 0; f < frames; f++)
         for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
               sendPixel(g, (mode == 0) ? rampPix(r, c) : PIX'($urandom), gap_max);
      in_valid[g] = 1'b0;
   endtask

   task automatic drain(input int g);
      rnd_ready[g] = 1'b0;
      out_ready[g] = 1'b1;
      in_valid[g]  = 1'b0;
      repeat (3) tick(g);
      checkOutput("drain_empty", pend[g], 1'b0);
   endtask

   initial begin
      int base;
      rst = 1'b1;
      for (int g = 0; g < 2; g++) begin
         in_valid[g]  = 1'b0;
         out_ready[g] = 1'b1;
         data_in[g]   = '0;
         rnd_ready[g] = 1'b0;
      end
      repeat (3) tick(0);
      rst = 1'b0;
      tick(0);

      $display("[TB] stride 1 ramp frame");
      base = log_n[0];
      applyStimulus(0, 0, 1, 0);
      drain(0);
      checkOutput("s1_count", log_n[0] - base, 16);
      checkOutput("s1_first", log_data[0][base], packList(first_v));
      checkOutput("s1_first_row", log_row[0][base], 0);
      checkOutput("s1_first_col", log_col[0][base], 0);
      checkOutput("s1_mid_data", log_data[0][base+5], packList(mid_v));
      checkOutput("s1_mid_row", log_row[0][base+5], 1);
      checkOutput("s1_mid_col", log_col[0][base+5], 1);
      checkOutput("s1_prelast_flag", log_last[0][base+14], 1'b0);
      checkOutput("s1_last_data", log_data[0][base+15], packList(last_v));
      checkOutput("s1_last_flag", log_last[0][base+15], 1'b1);

      $display("[TB] stride 2 ramp frame");
      base = log_n[1];
      applyStimulus(1, 0, 1, 0);
      drain(1);
      checkOutput("s2_count", log_n[1] - base, 4);
      for (int i = 0; i < 4; i++) begin
         checkOutput("s2_row", log_row[1][base+i], (i/2)*2);
         checkOutput("s2_col", log_col[1][base+i], (i%2)*2);
         checkOutput("s2_last", log_last[1][base+i], i == 3);
         checkOutput("s2_data", log_data[1][base+i], rampWin((i/2)*2, (i%2)*2));
      end

      $display("[TB] backpressure");
      base = log_n[0];
      for (int p = 0; p < 15; p++) sendPixel(0, rampPix(p / W, p % W), 0);
      checkOutput("bp_valid_rise", out_valid[0], 1'b1);
      out_ready[0] = 1'b0;
      in_valid[0]  = 1'b1;
      data_in[0]   = rampPix(2, 3);
      #1;
      checkOutput("bp_in_ready_rise", in_ready[0], 1'b0);
      repeat (10) begin
         @(posedge clk);
         #1;
         checkOutput("bp_in_ready", in_ready[0], 1'b0);
         checkOutput("bp_valid", out_valid[0], 1'b1);
         checkOutput("bp_hold", data_out[0], packList(first_v));
      end
      out_ready[0] = 1'b1;
      for (int p = 15; p < W*H; p++) sendPixel(0, rampPix(p / W, p % W), 0);
      drain(0);
      checkOutput("bp_count", log_n[0] - base, 16);

      $display("[TB] back-to-back frames");
      base = log_n[0];
      applyStimulus(0, 0, 2, 0);
      drain(0);
      checkOutput("b2b_count", log_n[0] - base, 32);
      for (int i = 0; i < 16; i++)
         checkOutput("b2b_frame2", log_data[0][base+16+i], rampWin(i/4, i%4));
      checkOutput("b2b_last1", log_last[0][base+15], 1'b1);
      checkOutput("b2b_last2", log_last[0][base+31], 1'b1);

      $display("[TB] random data, gaps and ready");
      rnd_ready[0] = 1'b1;
      applyStimulus(0, 1, 3, 2);
      drain(0);
      rnd_ready[1] = 1'b1;
      applyStimulus(1, 1, 2, 2);
      drain(1);

      $display("[TB] reset mid-frame");
      for (int p = 0; p < 20; p++) sendPixel(0, rampPix(p / W, p % W), 0);
      in_valid[0] = 1'b0;
      tick(0);
      tick(0);
      rst = 1'b1;
      repeat (3) begin
         tick(0);
         checkOutput("mr_valid", out_valid[0], 1'b0);
         checkOutput("mr_in_ready", in_ready[0], 1'b0);
      end
      rst = 1'b0;
      tick(0);
      base = log_n[0];
      applyStimulus(0, 0, 1, 0);
      drain(0);
      checkOutput("mr_count", log_n[0] - base, 16);
      checkOutput("mr_first", log_data[0][base], packList(first_v));
      checkOutput("mr_first_row", log_row[0][base], 0);
      checkOutput("mr_first_col", log_col[0][base], 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #300000;
      $display("[TB] FAIL global_timeout: simulation did not complete");
      $fatal(1, "[TB] timeout");
   end

endmodule
